uart_rx: RTL and testbench

- 8N1 UART receiver, the receive-side counterpart of the UartTx transmitter. It samples an asynchronous serial line and delivers each received byte as a one-cycle strobe. Stop-bit failures are reported as frame errors.
- It sits between a board I/O pin (e.g. ck_io12) and downstream byte consumers such as a FIFO or command parser.
- There is no backpressure. The consumer must capture data_o in the cycle valid_o is high.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side and serial-line signals of the 8N1 UART receiver.
// The slave modport is the receiver; the master modport drives the line and consumes bytes.
interface uart_rx_if;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  modport master (
    output rx_i,
    input  data_o,
    input  valid_o,
    input  frame_err_o,
    input  busy_o
  );

  modport slave (
    input  rx_i,
    output data_o,
    output valid_o,
    output frame_err_o,
    output busy_o
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and
// one-cycle byte / frame-error strobes.
module uart_rx #(
  parameter int CLK_FREQ = 125_000_000,
  parameter int BAUD     = 115_200
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  localparam int N    = CLK_FREQ / BAUD;
  localparam int HALF = N / 2;
  localparam int CW   = $clog2(N);

  localparam logic [CW-1:0] MID  = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (N < 4) begin : g_n_check
      $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          s1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [2:0]    idx;
  logic [2:0]    idx_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic [7:0]    data;
  logic [7:0]    data_next;
  logic          valid;
  logic          valid_next;
  logic          err;
  logic          err_next;

  // Synchronizer flops reset to the idle line level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b1;
      rx_s  <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      data  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      s1    <= bus.rx_i;
      rx_s  <= s1;
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shift <= shift_next;
      data  <= data_next;
      valid <= valid_next;
      err   <= err_next;
    end
  end

  // The counter restarts on every state change and after each data sample,
  // so each bit is sampled N cycles after the previous one.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    idx_next   = idx;
    shift_next = shift;
    data_next  = data;
    valid_next = 1'b0;
    err_next   = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          state_next = START;
        end
      end

      START: begin
        if (cnt == MID) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt == LAST) begin
          cnt_next        = '0;
          shift_next[idx] = rx_s;
          idx_next        = idx + 3'd1;
          if (idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end

      // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
      STOP: begin
        if (cnt == LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next  = shift;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end

      // A held-low line (break) must go high again before a new start is accepted.
      WAIT_IDLE: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.data_o      = data;
  assign bus.valid_o     = valid;
  assign bus.frame_err_o = err;
  assign bus.busy_o      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed vector table, hand-written corner sequences and
// randomized frames checked against a sample-point model of the serial line.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_700_000;
  localparam int BAUD     = 100_000;
  localparam int N        = CLK_FREQ / BAUD;
  localparam int HALF     = N / 2;
  localparam int LAT      = 2 + HALF + 9 * N;
  localparam int MAXC     = 16384;
  localparam int MAXE     = 64;

  localparam int K_VALID  = 0;
  localparam int K_ERR    = 1;
  localparam int K_GLITCH = 2;

  typedef struct {
    logic [7:0] data;
    bit         stop_level;
    int         skew_pct;
    int         hold_low;
    int         gap;
    int         kind;
    logic [7:0] expect_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       valid_log [MAXC];
  logic       err_log   [MAXC];
  logic       busy_log  [MAXC];
  logic [7:0] data_log  [MAXC];

  // Outputs are logged on the falling edge, indexed by the number of rising edges so far.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      valid_log[cyc] <= bus.valid_o;
      err_log[cyc]   <= bus.frame_err_o;
      busy_log[cyc]  <= bus.busy_o;
      data_log[cyc]  <= bus.data_o;
    end
  end

  int vectors    = 0;
  int miscompares = 0;

  int         exp_e0   [MAXE];
  int         exp_kind [MAXE];
  int         exp_rel  [MAXE];
  logic [7:0] exp_data [MAXE];
  int         n_exp    = 0;
  logic [7:0] last_data = 8'h00;

  vec_t table_v [7];

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic real bit_time(input int skew_pct);
    return real'(N) * 100.0 / (100.0 + real'(skew_pct));
  endfunction

  // Model: the receiver looks at the line HALF + k*N cycles after the start edge
  // (k = 0 start, 1..8 data LSB first, 9 stop); the line bit there follows from the bit period.
  task automatic model_frame(input logic [7:0] d, input bit stop_level, input int skew_pct,
                             output int kind, output logic [7:0] data);
    real  tbits;
    logic line [10];
    logic smp  [10];
    int   pos;
    tbits   = bit_time(skew_pct);
    line[0] = 1'b0;
    for (int i = 0; i < 8; i++) line[i + 1] = d[i];
    line[9] = stop_level;
    for (int k = 0; k < 10; k++) begin
      pos    = int'($floor(real'(HALF + k * N) / tbits));
      smp[k] = (pos > 9) ? 1'b1 : line[pos];
    end
    data = last_data;
    if (smp[0]) begin
      kind = K_GLITCH;
    end else if (smp[9]) begin
      kind = K_VALID;
      for (int i = 0; i < 8; i++) data[i] = smp[i + 1];
    end else begin
      kind = K_ERR;
    end
  endtask

  task automatic record(input int e0, input int kind, input logic [7:0] data, input int rel);
    exp_e0[n_exp]   = e0;
    exp_kind[n_exp] = kind;
    exp_data[n_exp] = data;
    exp_rel[n_exp]  = rel;
    n_exp++;
    if (kind == K_VALID) last_data = data;
  endtask

  task automatic idle_high(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_i = 1'b1;
    end
  endtask

  // Drives one frame whose bits last N*100/(100+skew) cycles each, then optional
  // extra low cycles, then gap idle-high cycles. e0 is the first rising edge seeing the start bit.
  task automatic applyStimulus(input logic [7:0] d, input bit stop_level, input int skew_pct,
                               input int hold_low, input int gap, output int e0, output int rel);
    real  tbits;
    logic line [10];
    int   c;
    int   pos;
    tbits   = bit_time(skew_pct);
    line[0] = 1'b0;
    for (int i = 0; i < 8; i++) line[i + 1] = d[i];
    line[9] = stop_level;
    e0  = -1;
    rel = -1;
    c   = 0;
    pos = 0;
    while (pos <= 9) begin
      @(negedge clk);
      if (c == 0) e0 = cyc + 1;
      bus.rx_i = line[pos];
      c++;
      pos = int'($floor(real'(c) / tbits));
    end
    repeat (hold_low) begin
      @(negedge clk);
      bus.rx_i = 1'b0;
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (g == 0) rel = cyc + 1;
      bus.rx_i = 1'b1;
    end
  endtask

  task automatic checkOutput(input int i);
    int e0;
    int t;
    int nv;
    int ne;
    int nlow;
    e0 = exp_e0[i];
    t  = e0 + LAT;
    nv = 0;
    ne = 0;
    for (int c = e0; c <= t + 3; c++) begin
      if (valid_log[c] === 1'b1) nv++;
      if (err_log[c] === 1'b1) ne++;
    end
    compare($sformatf("frame%0d busy_before_start", i), busy_log[e0 + 1], 1'b0);
    compare($sformatf("frame%0d busy_after_sync", i), busy_log[e0 + 2], 1'b1);
    case (exp_kind[i])
      K_VALID: begin
        compare($sformatf("frame%0d valid_count", i), nv, 1);
        compare($sformatf("frame%0d err_count", i), ne, 0);
        compare($sformatf("frame%0d valid_at_latency", i), valid_log[t], 1'b1);
        compare($sformatf("frame%0d data", i), data_log[t], exp_data[i]);
        compare($sformatf("frame%0d busy_after_stop", i), busy_log[t], 1'b0);
      end
      K_ERR: begin
        nlow = 0;
        for (int c = e0 + 2; c <= exp_rel[i] + 1; c++) begin
          if (busy_log[c] !== 1'b1) nlow++;
        end
        compare($sformatf("frame%0d valid_count", i), nv, 0);
        compare($sformatf("frame%0d err_count", i), ne, 1);
        compare($sformatf("frame%0d err_at_latency", i), err_log[t], 1'b1);
        compare($sformatf("frame%0d data_kept", i), data_log[t], exp_data[i]);
        compare($sformatf("frame%0d busy_low_during_break", i), nlow, 0);
        compare($sformatf("frame%0d busy_after_release", i), busy_log[exp_rel[i] + 2], 1'b0);
      end
      default: begin
        compare($sformatf("frame%0d glitch_valid_count", i), nv, 0);
        compare($sformatf("frame%0d glitch_err_count", i), ne, 0);
        compare($sformatf("frame%0d glitch_busy_mid", i), busy_log[e0 + 1 + HALF], 1'b1);
        compare($sformatf("frame%0d glitch_busy_end", i), busy_log[e0 + 2 + HALF], 1'b0);
        compare($sformatf("frame%0d glitch_data_kept", i), data_log[t], exp_data[i]);
      end
    endcase
  endtask

  initial begin
    int         e0;
    int         rel;
    int         kind;
    int         c;
    int         skew;
    int         gap;
    int         hold;
    int         strobes;
    int         want;
    bit         stop_level;
    logic [7:0] d;
    logic [7:0] md;

    table_v[0] = '{8'h45, 1'b1,  0, 0,     20, K_VALID, 8'h45};
    table_v[1] = '{8'h00, 1'b1,  0, 0,      0, K_VALID, 8'h00};
    table_v[2] = '{8'hFF, 1'b1,  0, 0,     20, K_VALID, 8'hFF};
    table_v[3] = '{8'h55, 1'b0,  0, 3 * N, 20, K_ERR,   8'hFF};
    table_v[4] = '{8'hA3, 1'b1,  0, 0,     20, K_VALID, 8'hA3};
    table_v[5] = '{8'h3C, 1'b1,  2, 0,     20, K_VALID, 8'h3C};
    table_v[6] = '{8'h3C, 1'b1, -2, 0,     20, K_VALID, 8'h3C};

    rst      = 1'b0;
    bus.rx_i = 1'b1;
    repeat (3) @(negedge clk);
    compare("reset data", bus.data_o, 8'h00);
    compare("reset valid", bus.valid_o, 1'b0);
    compare("reset frame_err", bus.frame_err_o, 1'b0);
    compare("reset busy", bus.busy_o, 1'b0);
    rst = 1'b1;
    idle_high(10);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(table_v[v].data, table_v[v].stop_level, table_v[v].skew_pct,
                    table_v[v].hold_low, table_v[v].gap, e0, rel);
      record(e0, table_v[v].kind, table_v[v].expect_data, rel);
    end

    // Short low pulse: start is rejected at the mid-start-bit sample.
    @(negedge clk);
    e0       = cyc + 1;
    bus.rx_i = 1'b0;
    repeat (HALF - 4) begin
      @(negedge clk);
      bus.rx_i = 1'b0;
    end
    idle_high(LAT + 40);
    record(e0, K_GLITCH, last_data, -1);

    // Reset in the middle of data bit 4 of 0x3C.
    d = 8'h3C;
    c = 0;
    while (c < 5 * N + HALF) begin
      @(negedge clk);
      bus.rx_i = (c < N) ? 1'b0 : d[c / N - 1];
      c++;
    end
    @(negedge clk);
    rst      = 1'b0;
    bus.rx_i = 1'b1;
    @(negedge clk);
    compare("midframe reset data", bus.data_o, 8'h00);
    compare("midframe reset valid", bus.valid_o, 1'b0);
    compare("midframe reset frame_err", bus.frame_err_o, 1'b0);
    compare("midframe reset busy", bus.busy_o, 1'b0);
    rst       = 1'b1;
    last_data = 8'h00;
    idle_high(3 * N);
    applyStimulus(8'h81, 1'b1, 0, 0, 20, e0, rel);
    record(e0, K_VALID, 8'h81, rel);

    for (int r = 0; r < 24; r++) begin
      d          = 8'($urandom);
      skew       = int'($urandom_range(6, 0)) - 3;
      stop_level = ($urandom_range(4, 0) != 0);
      hold       = stop_level ? 0 : int'($urandom_range(2 * N, 0));
      gap        = stop_level ? int'($urandom_range(12, 0)) : int'($urandom_range(20, 4));
      model_frame(d, stop_level, skew, kind, md);
      applyStimulus(d, stop_level, skew, hold, gap, e0, rel);
      record(e0, kind, md, rel);
    end

    idle_high(LAT + 60);

    for (int i = 0; i < n_exp; i++) begin
      checkOutput(i);
    end

    strobes = 0;
    want    = 0;
    for (int i = 0; i < cyc && i < MAXC; i++) begin
      if (valid_log[i] === 1'b1) strobes++;
      if (err_log[i] === 1'b1) strobes++;
      if (valid_log[i] === 1'b1 && err_log[i] === 1'b1) begin
        compare($sformatf("strobes_exclusive@%0d", i), 1, 0);
      end
    end
    for (int i = 0; i < n_exp; i++) begin
      if (exp_kind[i] != K_GLITCH) want++;
    end
    compare("total strobe count", strobes, want);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
